// File: rtl/bp_update_scheduler_if.sv
// Bundle of lookup, resolved-update and PHT-port signals for bp_update_scheduler.
// The slave modport is the scheduler's view; master is the surrounding pipeline/PHT.
interface bp_update_scheduler_if #(
  parameter int IDX_W = 6
);
  logic              lk_valid;
  logic [31:0]       lk_pc;
  logic              lk_ready;
  logic              lk_rsp_valid;
  logic              lk_taken;

  logic              up_valid;
  logic [31:0]       up_pc;
  logic              up_taken;
  logic              up_ready;

  logic              pht_en;
  logic              pht_we;
  logic [IDX_W-1:0]  pht_addr;
  logic [1:0]        pht_wdata;
  logic [1:0]        pht_rdata;

  logic              busy;

  modport slave (
    input  lk_valid, lk_pc, up_valid, up_pc, up_taken, pht_rdata,
    output lk_ready, lk_rsp_valid, lk_taken, up_ready,
           pht_en, pht_we, pht_addr, pht_wdata, busy
  );

  modport master (
    output lk_valid, lk_pc, up_valid, up_pc, up_taken, pht_rdata,
    input  lk_ready, lk_rsp_valid, lk_taken, up_ready,
           pht_en, pht_we, pht_addr, pht_wdata, busy
  );
endinterface

// File: rtl/bp_update_scheduler.sv
// Branch-predictor PHT update scheduler: arbitrates lookups against queued 2-bit counter updates.
// Optional feature macro BPS_STARVE_GUARD_EN adds a starvation counter that forces pending updates.
module bp_update_scheduler #(
  parameter int IDX_W      = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  bp_update_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {INIT, IDLE, UPD_WR} state_t;

  state_t           state;
  logic [IDX_W-1:0] init_cnt;
  logic [IDX_W-1:0] fifo_idx   [FIFO_DEPTH];
  logic             fifo_taken [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] hold_idx;
  logic             hold_taken;
  logic             rsp_valid;

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] up_idx;
  logic             full;
  logic             empty;
  logic             force_upd;
  logic             lk_grant;
  logic             up_grant;
  logic             push;
  logic             pop;

  logic             pht_en;
  logic             pht_we;
  logic [IDX_W-1:0] pht_addr;
  logic [1:0]       pht_wdata;

  logic             unused_pc_bits;

  function automatic logic [1:0] sat_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? 2'b11 : c + 2'b01;
    else       return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  assign lk_idx = bus.lk_pc[IDX_W+1:2];
  assign up_idx = bus.up_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{bus.lk_pc[31:IDX_W+2], bus.lk_pc[1:0],
                            bus.up_pc[31:IDX_W+2], bus.up_pc[1:0]};

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);

`ifdef BPS_STARVE_GUARD_EN
  localparam int SV_W = $clog2(STARVE_MAX + 1);
  logic [SV_W-1:0] starve_cnt;

  assign force_upd = full || (starve_cnt == SV_W'(STARVE_MAX));

  // Counts IDLE cycles in which a waiting update lost to a lookup.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (up_grant) begin
      starve_cnt <= '0;
    end else if (lk_grant && !empty) begin
      starve_cnt <= starve_cnt + SV_W'(1);
    end
  end
`else
  assign force_upd = full;
`endif

  assign lk_grant = (state == IDLE) && bus.lk_valid && !force_upd;
  assign up_grant = (state == IDLE) && !empty && (!bus.lk_valid || force_upd);
  // A full queue refuses pushes even when it pops in the same cycle.
  assign push     = bus.up_valid && !full;
  assign pop      = up_grant;

  // PHT port: INIT sweep, lookup/update reads in IDLE, read-modify-write completion in UPD_WR.
  always_comb begin
    pht_en    = 1'b0;
    pht_we    = 1'b0;
    pht_addr  = '0;
    pht_wdata = 2'b00;
    unique case (state)
      INIT: begin
        pht_en    = 1'b1;
        pht_we    = 1'b1;
        pht_addr  = init_cnt;
        pht_wdata = 2'b01;
      end
      IDLE: begin
        if (lk_grant) begin
          pht_en   = 1'b1;
          pht_addr = lk_idx;
        end else if (up_grant) begin
          pht_en   = 1'b1;
          pht_addr = fifo_idx[rd_ptr];
        end
      end
      UPD_WR: begin
        pht_en    = 1'b1;
        pht_we    = 1'b1;
        pht_addr  = hold_idx;
        pht_wdata = sat_next(bus.pht_rdata, hold_taken);
      end
      default: ;
    endcase
    if (!reset) begin
      pht_en    = 1'b0;
      pht_we    = 1'b0;
      pht_addr  = '0;
      pht_wdata = 2'b00;
    end
  end

  assign bus.pht_en       = pht_en;
  assign bus.pht_we       = pht_we;
  assign bus.pht_addr     = pht_addr;
  assign bus.pht_wdata    = pht_wdata;
  assign bus.lk_ready     = lk_grant;
  assign bus.lk_rsp_valid = rsp_valid;
  assign bus.lk_taken     = rsp_valid & bus.pht_rdata[1];
  assign bus.up_ready     = !full;
  assign bus.busy         = (state == INIT) || !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr]   <= up_idx;
      fifo_taken[wr_ptr] <= bus.up_taken;
    end
  end

  // Main FSM plus queue pointers, holding register and lookup response flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= INIT;
      init_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      hold_idx   <= '0;
      hold_taken <= 1'b0;
      rsp_valid  <= 1'b0;
    end else begin
      rsp_valid <= lk_grant;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
      unique case (state)
        INIT: begin
          init_cnt <= init_cnt + IDX_W'(1);
          if (init_cnt == '1) state <= IDLE;
        end
        IDLE: begin
          if (up_grant) begin
            hold_idx   <= fifo_idx[rd_ptr];
            hold_taken <= fifo_taken[rd_ptr];
            state      <= UPD_WR;
          end
        end
        UPD_WR:  state <= IDLE;
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed self-checking bench for bp_update_scheduler with a synchronous 2-bit PHT memory model.
module tb_bp_update_scheduler;
  localparam int IDX_W = 6;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bp_update_scheduler_if #(.IDX_W(IDX_W)) bus ();

  bp_update_scheduler #(.IDX_W(IDX_W), .FIFO_DEPTH(4), .STARVE_MAX(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [1:0] pht_mem [0:63];
  logic [1:0] pht_q = 2'b00;
  assign bus.pht_rdata = pht_q;

  always @(posedge clk) begin
    if (bus.pht_en) begin
      if (bus.pht_we) pht_mem[bus.pht_addr] <= bus.pht_wdata;
      else            pht_q <= pht_mem[bus.pht_addr];
    end
  end

  int tests_run    = 0;
  int tests_failed = 0;

  logic [1:0] wr_log_data [0:15];
  logic [5:0] wr_log_addr [0:15];
  int         wr_count;
  bit         timed_out;

  // Drains the queue with lk_valid low, pushing n identical updates and logging every PHT write.
  task automatic run_updates(input logic [31:0] pc, input logic tk, input int n);
    int pushed = 0;
    bit done = 0;
    wr_count  = 0;
    timed_out = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      bus.lk_valid = 1'b0;
      bus.up_valid = (pushed < n);
      bus.up_pc    = pc;
      bus.up_taken = tk;
      #1;
      if (bus.pht_en && bus.pht_we && wr_count < 16) begin
        wr_log_data[wr_count] = bus.pht_wdata;
        wr_log_addr[wr_count] = bus.pht_addr;
        wr_count++;
      end
      if (bus.up_valid && bus.up_ready) pushed++;
      if (pushed == n && !bus.up_valid && !bus.busy) done = 1;
    end
    if (!done) timed_out = 1'b1;
    @(negedge clk);
    bus.up_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    bus.lk_valid = 1'b0;
    bus.lk_pc    = 32'h0;
    bus.up_valid = 1'b0;
    bus.up_pc    = 32'h0;
    bus.up_taken = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (bus.lk_ready !== 1'b0 || bus.lk_rsp_valid !== 1'b0 || bus.lk_taken !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_lookup: lk_ready=%b rsp_valid=%b taken=%b, expected 0 0 0",
               bus.lk_ready, bus.lk_rsp_valid, bus.lk_taken);
    end
    tests_run++;
    if (bus.up_ready !== 1'b1 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_status: up_ready=%b busy=%b, expected 1 1", bus.up_ready, bus.busy);
    end
    tests_run++;
    if (bus.pht_en !== 1'b0 || bus.pht_we !== 1'b0 || bus.pht_addr !== 6'd0 || bus.pht_wdata !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset_pht: en=%b we=%b addr=%0d wdata=%b, expected 0 0 0 00",
               bus.pht_en, bus.pht_we, bus.pht_addr, bus.pht_wdata);
    end
  endtask

  task automatic test_init();
    @(negedge clk);
    reset        = 1'b1;
    bus.lk_valid = 1'b1;
    bus.lk_pc    = 32'h0;
    for (int i = 0; i < 64; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      tests_run++;
      if (!(bus.pht_en === 1'b1 && bus.pht_we === 1'b1 && bus.pht_addr === 6'(i) &&
            bus.pht_wdata === 2'b01 && bus.lk_ready === 1'b0 && bus.busy === 1'b1)) begin
        tests_failed++;
        $display("[TB] FAIL init_write cycle %0d: en=%b we=%b addr=%0d wdata=%b lk_ready=%b, expected 1 1 %0d 01 0",
                 i + 1, bus.pht_en, bus.pht_we, bus.pht_addr, bus.pht_wdata, bus.lk_ready, i);
      end
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (bus.lk_ready !== 1'b1 || bus.pht_we !== 1'b0 || bus.pht_addr !== 6'd0) begin
      tests_failed++;
      $display("[TB] FAIL init_first_grant: lk_ready=%b we=%b addr=%0d, expected 1 0 0",
               bus.lk_ready, bus.pht_we, bus.pht_addr);
    end
    @(negedge clk);
    bus.lk_valid = 1'b0;
    #1;
    tests_run++;
    if (bus.lk_rsp_valid !== 1'b1 || bus.lk_taken !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL init_first_rsp: rsp_valid=%b taken=%b busy=%b, expected 1 0 0",
               bus.lk_rsp_valid, bus.lk_taken, bus.busy);
    end
  endtask

  task automatic test_lookup();
    @(negedge clk);
    bus.lk_valid = 1'b1;
    bus.lk_pc    = 32'h8000_0004;
    #1;
    tests_run++;
    if (bus.lk_ready !== 1'b1 || bus.pht_en !== 1'b1 || bus.pht_we !== 1'b0 || bus.pht_addr !== 6'd1) begin
      tests_failed++;
      $display("[TB] FAIL lookup_grant: lk_ready=%b en=%b we=%b addr=%0d, expected 1 1 0 1",
               bus.lk_ready, bus.pht_en, bus.pht_we, bus.pht_addr);
    end
    @(negedge clk);
    bus.lk_valid = 1'b0;
    #1;
    tests_run++;
    if (bus.lk_rsp_valid !== 1'b1 || bus.lk_taken !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL lookup_rsp: rsp_valid=%b taken=%b, expected 1 0", bus.lk_rsp_valid, bus.lk_taken);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (bus.lk_rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL lookup_no_rsp: rsp_valid=%b, expected 0", bus.lk_rsp_valid);
    end
  endtask

  task automatic test_saturation();
    run_updates(32'h8000_0004, 1'b1, 3);
    tests_run++;
    if (timed_out || wr_count != 3) begin
      tests_failed++;
      $display("[TB] FAIL sat_taken_count: writes=%0d timeout=%b, expected 3 0", wr_count, timed_out);
    end else begin
      tests_run++;
      if (wr_log_data[0] !== 2'b10 || wr_log_data[1] !== 2'b11 || wr_log_data[2] !== 2'b11 ||
          wr_log_addr[0] !== 6'd1 || wr_log_addr[1] !== 6'd1 || wr_log_addr[2] !== 6'd1) begin
        tests_failed++;
        $display("[TB] FAIL sat_taken_data: got %b@%0d %b@%0d %b@%0d, expected 10@1 11@1 11@1",
                 wr_log_data[0], wr_log_addr[0], wr_log_data[1], wr_log_addr[1], wr_log_data[2], wr_log_addr[2]);
      end
    end
    @(negedge clk);
    bus.lk_valid = 1'b1;
    bus.lk_pc    = 32'h8000_0004;
    @(negedge clk);
    bus.lk_valid = 1'b0;
    #1;
    tests_run++;
    if (bus.lk_rsp_valid !== 1'b1 || bus.lk_taken !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL sat_taken_lookup: rsp_valid=%b taken=%b, expected 1 1", bus.lk_rsp_valid, bus.lk_taken);
    end
    run_updates(32'h8000_0008, 1'b0, 3);
    tests_run++;
    if (timed_out || wr_count != 3 || wr_log_data[0] !== 2'b00 || wr_log_data[1] !== 2'b00 ||
        wr_log_data[2] !== 2'b00 || wr_log_addr[0] !== 6'd2) begin
      tests_failed++;
      $display("[TB] FAIL sat_not_taken: writes=%0d data=%b %b %b addr=%0d, expected 3 00 00 00 2",
               wr_count, wr_log_data[0], wr_log_data[1], wr_log_data[2], wr_log_addr[0]);
    end
  endtask

  task automatic test_queue_full();
    bus.up_pc    = 32'h8000_000C;
    bus.up_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.lk_valid = 1'b1;
      bus.lk_pc    = 32'h8000_0010;
      bus.up_valid = 1'b1;
      #1;
      tests_run++;
      if (bus.up_ready !== 1'b1 || bus.lk_ready !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL full_fill push %0d: up_ready=%b lk_ready=%b, expected 1 1",
                 i + 1, bus.up_ready, bus.lk_ready);
      end
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (bus.up_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL full_fifth_push: up_ready=%b, expected 0", bus.up_ready);
    end
    tests_run++;
    if (bus.lk_ready !== 1'b0 || bus.pht_en !== 1'b1 || bus.pht_we !== 1'b0 || bus.pht_addr !== 6'd3) begin
      tests_failed++;
      $display("[TB] FAIL full_forced_grant: lk_ready=%b en=%b we=%b addr=%0d, expected 0 1 0 3",
               bus.lk_ready, bus.pht_en, bus.pht_we, bus.pht_addr);
    end
    @(negedge clk);
    bus.up_valid = 1'b0;
    #1;
    tests_run++;
    if (bus.pht_we !== 1'b1 || bus.pht_addr !== 6'd3 || bus.pht_wdata !== 2'b10 || bus.lk_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL full_write: we=%b addr=%0d wdata=%b lk_ready=%b, expected 1 3 10 0",
               bus.pht_we, bus.pht_addr, bus.pht_wdata, bus.lk_ready);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (bus.lk_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL full_lookup_resumes: lk_ready=%b, expected 1", bus.lk_ready);
    end
    run_updates(32'h8000_000C, 1'b1, 0);
    tests_run++;
    if (timed_out || wr_count != 3 || wr_log_data[0] !== 2'b11 || wr_log_data[2] !== 2'b11 ||
        wr_log_addr[2] !== 6'd3) begin
      tests_failed++;
      $display("[TB] FAIL full_drain: writes=%0d timeout=%b first=%b last=%b@%0d, expected 3 0 11 11@3",
               wr_count, timed_out, wr_log_data[0], wr_log_data[2], wr_log_addr[2]);
    end
  endtask

  task automatic test_starvation();
    int  grants  = 0;
    bit  granted = 0;
    @(negedge clk);
    bus.lk_valid = 1'b1;
    bus.lk_pc    = 32'h8000_0014;
    bus.up_valid = 1'b1;
    bus.up_pc    = 32'h8000_0018;
    bus.up_taken = 1'b0;
    #1;
    tests_run++;
    if (bus.lk_ready !== 1'b1 || bus.up_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL starve_start: lk_ready=%b up_ready=%b, expected 1 1", bus.lk_ready, bus.up_ready);
    end
    for (int c = 0; c < 20 && !granted; c++) begin
      @(negedge clk);
      bus.up_valid = 1'b0;
      #1;
      if (bus.lk_ready === 1'b1) grants++;
      else if (bus.pht_en === 1'b1 && bus.pht_we === 1'b0 && bus.pht_addr === 6'd6) granted = 1;
    end
`ifdef BPS_STARVE_GUARD_EN
    tests_run++;
    if (!granted || grants != 8) begin
      tests_failed++;
      $display("[TB] FAIL starve_forced: granted=%b lookup_grants=%0d, expected 1 8", granted, grants);
    end
`else
    tests_run++;
    if (granted || grants != 20) begin
      tests_failed++;
      $display("[TB] FAIL starve_absent: granted=%b lookup_grants=%0d, expected 0 20", granted, grants);
    end
    @(negedge clk);
    bus.lk_valid = 1'b0;
    #1;
    tests_run++;
    if (bus.pht_en !== 1'b1 || bus.pht_we !== 1'b0 || bus.pht_addr !== 6'd6 || bus.lk_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL starve_drop_grant: en=%b we=%b addr=%0d lk_ready=%b, expected 1 0 6 0",
               bus.pht_en, bus.pht_we, bus.pht_addr, bus.lk_ready);
    end
`endif
    run_updates(32'h8000_0018, 1'b0, 0);
    tests_run++;
    if (timed_out || wr_count != 1 || wr_log_data[0] !== 2'b00 || wr_log_addr[0] !== 6'd6) begin
      tests_failed++;
      $display("[TB] FAIL starve_write: writes=%0d data=%b addr=%0d, expected 1 00 6",
               wr_count, wr_log_data[0], wr_log_addr[0]);
    end
  endtask

  task automatic test_reset_mid_update();
    @(negedge clk);
    bus.lk_valid = 1'b0;
    bus.up_valid = 1'b1;
    bus.up_pc    = 32'h8000_0020;
    bus.up_taken = 1'b1;
    @(negedge clk);
    #1;
    tests_run++;
    if (bus.pht_en !== 1'b1 || bus.pht_we !== 1'b0 || bus.pht_addr !== 6'd8) begin
      tests_failed++;
      $display("[TB] FAIL mid_read: en=%b we=%b addr=%0d, expected 1 0 8", bus.pht_en, bus.pht_we, bus.pht_addr);
    end
    @(negedge clk);
    bus.up_valid = 1'b0;
    #1;
    tests_run++;
    if (bus.pht_we !== 1'b1 || bus.pht_addr !== 6'd8 || bus.pht_wdata !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL mid_upd_wr: we=%b addr=%0d wdata=%b, expected 1 8 10", bus.pht_we, bus.pht_addr, bus.pht_wdata);
    end
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (bus.pht_en !== 1'b0 || bus.pht_we !== 1'b0 || bus.busy !== 1'b1 || bus.up_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_outputs: en=%b we=%b busy=%b up_ready=%b, expected 0 0 1 1",
               bus.pht_en, bus.pht_we, bus.busy, bus.up_ready);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (pht_mem[8] !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL mid_write_discarded: pht[8]=%b, expected 01", pht_mem[8]);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++;
    if (bus.pht_en !== 1'b1 || bus.pht_we !== 1'b1 || bus.pht_addr !== 6'd0 || bus.pht_wdata !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL mid_init_restart: en=%b we=%b addr=%0d wdata=%b, expected 1 1 0 01",
               bus.pht_en, bus.pht_we, bus.pht_addr, bus.pht_wdata);
    end
    for (int cyc = 2; cyc <= 64; cyc++) begin
      @(negedge clk);
      bus.up_valid = (cyc == 5);
      bus.up_pc    = 32'h8000_001C;
      bus.up_taken = 1'b1;
      #1;
      if (cyc == 5) begin
        tests_run++;
        if (bus.up_ready !== 1'b1 || bus.busy !== 1'b1 || bus.lk_ready !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL init_push: up_ready=%b busy=%b lk_ready=%b, expected 1 1 0",
                   bus.up_ready, bus.busy, bus.lk_ready);
        end
      end
      if (cyc == 64) begin
        tests_run++;
        if (bus.pht_we !== 1'b1 || bus.pht_addr !== 6'd63) begin
          tests_failed++;
          $display("[TB] FAIL init_last: we=%b addr=%0d, expected 1 63", bus.pht_we, bus.pht_addr);
        end
      end
    end
    @(negedge clk);
    bus.up_valid = 1'b0;
    #1;
    tests_run++;
    if (bus.pht_en !== 1'b1 || bus.pht_we !== 1'b0 || bus.pht_addr !== 6'd7) begin
      tests_failed++;
      $display("[TB] FAIL init_queued_grant: en=%b we=%b addr=%0d, expected 1 0 7", bus.pht_en, bus.pht_we, bus.pht_addr);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (bus.pht_we !== 1'b1 || bus.pht_addr !== 6'd7 || bus.pht_wdata !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL init_queued_write: we=%b addr=%0d wdata=%b, expected 1 7 10",
               bus.pht_we, bus.pht_addr, bus.pht_wdata);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.pht_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_queue_flushed: busy=%b en=%b, expected 0 0", bus.busy, bus.pht_en);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_lookup();
    test_saturation();
    test_queue_full();
    test_starvation();
    test_reset_mid_update();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
